tcache_refill_ctrl: RTL and testbench

Refill engine on the responder side of the fetch micro-TLB (tcache) refill interface.
- On a tcache miss reported by fetch, it latches the request, searches the main TLB through its search port, then fetches the matching entry through the main TLB read port.
- It drives a single-cycle refill_valid/refill_data/refill_index pulse into the tcache, or reports a TLB-refill miss back to fetch.
- It sits between the fetch stage, the tcache and the main TLB, and handles TLB writes and INVTLB that occur mid-flight.

---
 rtl/tcache_refill_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tcache_refill_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcache_refill_ctrl.sv
// Refill engine for the fetch micro-TLB: on a tcache miss it searches the main TLB, reads the
// matching entry and installs it in the tcache, aborting cleanly on TLB writes or INVTLB.
package tcache_refill_pkg;
  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;
endpackage

module tcache_refill_ctrl
  import tcache_refill_pkg::*;
#(
  parameter int unsigned TLBNUM   = 16,
  parameter int unsigned TLBIDLEN = $clog2(TLBNUM)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [18:0]         req_vppn,
  input  logic                req_va_bit12,
  input  logic [9:0]          req_asid,
  output logic                resp_valid,
  output logic                resp_found,
  output logic                resp_retry,
  output logic [18:0]         tlb_s_vppn,
  output logic                tlb_s_va_bit12,
  output logic [9:0]          tlb_s_asid,
  input  logic                tlb_s_found,
  input  logic [TLBIDLEN-1:0] tlb_s_index,
  output logic [TLBIDLEN-1:0] tlb_r_index,
  input  tlb_entry_t          tlb_r_entry,
  input  logic                tlb_we,
  input  logic                invtlb_valid,
  output logic                refill_valid,
  output tlb_entry_t          refill_data,
  output logic [TLBIDLEN-1:0] refill_index
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEARCH = 3'd1;
  localparam logic [2:0] READ   = 3'd2;
  localparam logic [2:0] REFILL = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [18:0]         vppn_q, vppn_d;
  logic                bit12_q, bit12_d;
  logic [9:0]          asid_q, asid_d;
  logic [TLBIDLEN-1:0] s_index_q, s_index_d;
  tlb_entry_t          entry_q, entry_d;
  logic                found_q, found_d;
  logic                retry_q, retry_d;
  logic                flush;

  // Any main TLB change invalidates both the tcache and whatever we are carrying.
  assign flush = tlb_we | invtlb_valid;

  always_comb begin
    state_d   = state_q;
    vppn_d    = vppn_q;
    bit12_d   = bit12_q;
    asid_d    = asid_q;
    s_index_d = s_index_q;
    entry_d   = entry_q;
    found_d   = found_q;
    retry_d   = retry_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          vppn_d  = req_vppn;
          bit12_d = req_va_bit12;
          asid_d  = req_asid;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (flush) begin
          found_d = 1'b0;
          retry_d = 1'b1;
          state_d = DONE;
        end else if (!tlb_s_found) begin
          found_d = 1'b0;
          retry_d = 1'b0;
          state_d = DONE;
        end else begin
          s_index_d = tlb_s_index;
          state_d   = READ;
        end
      end
      READ: begin
        if (flush) begin
          found_d = 1'b0;
          retry_d = 1'b1;
          state_d = DONE;
        end else begin
          entry_d = tlb_r_entry;
          state_d = REFILL;
        end
      end
      REFILL: begin
        found_d = !flush;
        retry_d = flush;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      vppn_q    <= '0;
      bit12_q   <= 1'b0;
      asid_q    <= '0;
      s_index_q <= '0;
      entry_q   <= '0;
      found_q   <= 1'b0;
      retry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vppn_q    <= vppn_d;
      bit12_q   <= bit12_d;
      asid_q    <= asid_d;
      s_index_q <= s_index_d;
      entry_q   <= entry_d;
      found_q   <= found_d;
      retry_q   <= retry_d;
    end
  end

  always_comb begin
    req_ready      = (state_q == IDLE);
    tlb_s_vppn     = (state_q == SEARCH) ? vppn_q  : '0;
    tlb_s_va_bit12 = (state_q == SEARCH) ? bit12_q : 1'b0;
    tlb_s_asid     = (state_q == SEARCH) ? asid_q  : '0;
    tlb_r_index    = (state_q == READ || state_q == REFILL) ? s_index_q : '0;
    // A flush in REFILL suppresses the write; the tcache is clearing itself this cycle.
    refill_valid   = (state_q == REFILL) && !flush;
    refill_data    = refill_valid ? entry_q   : '0;
    refill_index   = refill_valid ? s_index_q : '0;
    resp_valid     = (state_q == DONE);
    resp_found     = resp_valid & found_q;
    resp_retry     = resp_valid & retry_q;
  end

endmodule

// File: tb/tb_tcache_refill_ctrl.sv
// Self-checking bench for tcache_refill_ctrl: table-driven requests against a behavioural main
// TLB, with a scoreboard of expected responses plus hand-written corner-case sequences.
module tb_tcache_refill_ctrl;
  import tcache_refill_pkg::*;

  localparam int unsigned TLBNUM   = 16;
  localparam int unsigned TLBIDLEN = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [18:0]         req_vppn = '0;
  logic                req_va_bit12 = 1'b0;
  logic [9:0]          req_asid = '0;
  logic                resp_valid, resp_found, resp_retry;
  logic [18:0]         tlb_s_vppn;
  logic                tlb_s_va_bit12;
  logic [9:0]          tlb_s_asid;
  logic                tlb_s_found;
  logic [TLBIDLEN-1:0] tlb_s_index;
  logic [TLBIDLEN-1:0] tlb_r_index;
  tlb_entry_t          tlb_r_entry;
  logic                tlb_we = 1'b0;
  logic                invtlb_valid = 1'b0;
  logic                refill_valid;
  tlb_entry_t          refill_data;
  logic [TLBIDLEN-1:0] refill_index;

  tcache_refill_ctrl #(.TLBNUM(TLBNUM), .TLBIDLEN(TLBIDLEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vppn(req_vppn),
    .req_va_bit12(req_va_bit12), .req_asid(req_asid),
    .resp_valid(resp_valid), .resp_found(resp_found), .resp_retry(resp_retry),
    .tlb_s_vppn(tlb_s_vppn), .tlb_s_va_bit12(tlb_s_va_bit12), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .tlb_we(tlb_we), .invtlb_valid(invtlb_valid),
    .refill_valid(refill_valid), .refill_data(refill_data), .refill_index(refill_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural main TLB: first matching valid entry wins.
  tlb_entry_t tlb_mem [TLBNUM];
  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (!tlb_s_found && tlb_mem[i].e && tlb_mem[i].vppn == tlb_s_vppn &&
          (tlb_mem[i].g || tlb_mem[i].asid == tlb_s_asid)) begin
        tlb_s_found = 1'b1;
        tlb_s_index = i[TLBIDLEN-1:0];
      end
    end
  end
  assign tlb_r_entry = tlb_mem[tlb_r_index];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit                  found;
    bit                  retry;
    bit                  refill;
    logic [TLBIDLEN-1:0] idx;
    tlb_entry_t          entry;
    int                  acc;
    int                  lat;
  } exp_t;
  exp_t exp_q[$];

  // Scoreboard monitor: samples on the falling edge, pops one expectation per response.
  initial begin
    bit                  seen_refill = 1'b0;
    logic [TLBIDLEN-1:0] r_idx = '0;
    tlb_entry_t          r_data = '0;
    int                  r_cyc = 0;
    exp_t                e;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen_refill = 1'b0;
      end else begin
        if (refill_valid) begin
          if (seen_refill) check("double_refill", 1, 0);
          seen_refill = 1'b1;
          r_idx  = refill_index;
          r_data = refill_data;
          r_cyc  = cyc;
        end
        if (!resp_valid) begin
          if (resp_found || resp_retry) check("resp_flags_idle", {resp_found, resp_retry}, 0);
        end else if (exp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
          seen_refill = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check("resp_found", resp_found, e.found);
          check("resp_retry", resp_retry, e.retry);
          check("resp_latency", cyc - e.acc, e.lat);
          check("refill_seen", seen_refill, e.refill);
          if (e.refill && seen_refill) begin
            check("refill_index", r_idx, e.idx);
            check("refill_data", r_data, e.entry);
            check("refill_latency", r_cyc - e.acc, 3);
          end
          seen_refill = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [18:0]         vppn;
    logic [9:0]          asid;
    int                  flush_at;  // 0 = none, else cycle offset from acceptance
    bit                  use_we;
    bit                  found;
    bit                  retry;
    bit                  refill;
    logic [TLBIDLEN-1:0] idx;
    int                  lat;
  } vec_t;
  vec_t vecs[$];

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("idle_timeout", req_ready, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check(name, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v, input int acc);
    exp_t e;
    e.found  = v.found;
    e.retry  = v.retry;
    e.refill = v.refill;
    e.idx    = v.idx;
    e.entry  = tlb_mem[v.idx];
    e.acc    = acc;
    e.lat    = v.lat;
    return e;
  endfunction

  task automatic run_vec(input vec_t v);
    wait_idle();
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_vppn  = v.vppn;
    req_asid  = v.asid;
    req_va_bit12 = v.vppn[0];
    exp_q.push_back(mk_exp(v, cyc));
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.flush_at > 0) begin
      repeat (v.flush_at - 1) @(posedge clk);
      #1;
      if (v.use_we) tlb_we = 1'b1;
      else invtlb_valid = 1'b1;
      @(posedge clk); #1;
      tlb_we = 1'b0;
      invtlb_valid = 1'b0;
    end
    drain("resp_timeout");
  endtask

  initial begin
    vec_t hv;
    int   t;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    int   t;
    for (int i = 0; i < TLBNUM; i++) tlb_mem[i] = '0;
    tlb_mem[5]  = '{vppn: 19'h12345, ps: 6'd12, g: 1'b0, asid: 10'd3, e: 1'b1,
                    ppn0: 20'hAAAAA, plv0: 2'd3, mat0: 2'd1, d0: 1'b1, v0: 1'b1,
                    ppn1: 20'h55555, plv1: 2'd0, mat1: 2'd2, d1: 1'b0, v1: 1'b1};
    tlb_mem[9]  = '{vppn: 19'h00ABC, ps: 6'd21, g: 1'b1, asid: 10'd7, e: 1'b1,
                    ppn0: 20'h01234, plv0: 2'd0, mat0: 2'd0, d0: 1'b0, v0: 1'b1,
                    ppn1: 20'hFEDCB, plv1: 2'd1, mat1: 2'd1, d1: 1'b1, v1: 1'b0};
    tlb_mem[12] = '{vppn: 19'h54321, ps: 6'd12, g: 1'b0, asid: 10'd1, e: 1'b1,
                    ppn0: 20'h0BEEF, plv0: 2'd2, mat0: 2'd1, d0: 1'b1, v0: 1'b0,
                    ppn1: 20'h0CAFE, plv1: 2'd3, mat1: 2'd0, d1: 1'b1, v1: 1'b1};
    tlb_mem[2]  = '{vppn: 19'h11111, ps: 6'd12, g: 1'b1, asid: 10'd0, e: 1'b0,
                    ppn0: 20'h11111, plv0: 2'd0, mat0: 2'd0, d0: 1'b0, v0: 1'b1,
                    ppn1: 20'h22222, plv1: 2'd0, mat1: 2'd0, d1: 1'b0, v1: 1'b1};

    //                 vppn      asid  flush we found retry refill idx lat
    vecs.push_back('{19'h12345, 10'd3,   0, 0, 1, 0, 1, 4'd5,  4});
    vecs.push_back('{19'h7FFFF, 10'd0,   0, 0, 0, 0, 0, 4'd0,  2});
    vecs.push_back('{19'h00ABC, 10'd200, 0, 0, 1, 0, 1, 4'd9,  4});
    vecs.push_back('{19'h54321, 10'd2,   0, 0, 0, 0, 0, 4'd0,  2});
    vecs.push_back('{19'h54321, 10'd1,   0, 0, 1, 0, 1, 4'd12, 4});
    vecs.push_back('{19'h11111, 10'd0,   0, 0, 0, 0, 0, 4'd0,  2});
    vecs.push_back('{19'h12345, 10'd3,   3, 0, 0, 1, 0, 4'd0,  4});
    vecs.push_back('{19'h12345, 10'd3,   1, 1, 0, 1, 0, 4'd0,  2});
    vecs.push_back('{19'h54321, 10'd1,   2, 0, 0, 1, 0, 4'd0,  3});
    vecs.push_back('{19'h7FFFF, 10'd0,   2, 1, 0, 0, 0, 4'd0,  2});
    vecs.push_back('{19'h00ABC, 10'd5,   4, 0, 1, 0, 1, 4'd9,  4});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_refill_valid", refill_valid, 0);
    check("rst_tlb_r_index", tlb_r_index, 0);
    check("rst_tlb_s_vppn", tlb_s_vppn, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Hit path with per-cycle port checks.
    hv = vecs[0];
    wait_idle();
    @(posedge clk); #1;
    req_valid = 1'b1; req_vppn = 19'h12345; req_asid = 10'd3; req_va_bit12 = 1'b1;
    t = cyc;
    exp_q.push_back(mk_exp(hv, t));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("hit_t1_s_vppn", tlb_s_vppn, 19'h12345);
    check("hit_t1_s_bit12", tlb_s_va_bit12, 1);
    check("hit_t1_req_ready", req_ready, 0);
    @(negedge clk);
    check("hit_t2_r_index", tlb_r_index, 5);
    check("hit_t2_s_vppn_zero", tlb_s_vppn, 0);
    @(negedge clk);
    check("hit_t3_refill_valid", refill_valid, 1);
    @(negedge clk);
    check("hit_t4_resp_valid", resp_valid, 1);
    @(negedge clk);
    check("hit_t5_req_ready", req_ready, 1);
    drain("hit_resp_timeout");

    // Flush in SEARCH: read port must stay idle.
    wait_idle();
    @(posedge clk); #1;
    req_valid = 1'b1; req_vppn = 19'h12345; req_asid = 10'd3;
    t = cyc;
    exp_q.push_back(mk_exp(vecs[7], t));
    @(posedge clk); #1;
    req_valid = 1'b0; tlb_we = 1'b1;
    @(posedge clk); #1;
    tlb_we = 1'b0;
    @(negedge clk);
    check("srch_flush_r_index", tlb_r_index, 0);
    check("srch_flush_refill", refill_valid, 0);
    drain("srch_flush_timeout");

    // Request coinciding with INVTLB is held off one cycle.
    wait_idle();
    @(posedge clk); #1;
    req_valid = 1'b1; req_vppn = 19'h12345; req_asid = 10'd3; invtlb_valid = 1'b1;
    @(posedge clk); #1;
    invtlb_valid = 1'b0;
    t = cyc;
    exp_q.push_back(mk_exp(vecs[0], t));
    @(negedge clk);
    check("flush_req_not_taken", req_ready, 1);
    check("flush_req_s_vppn", tlb_s_vppn, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain("flush_req_timeout");

    // Reset during READ: no response or refill afterwards.
    wait_idle();
    @(posedge clk); #1;
    req_valid = 1'b1; req_vppn = 19'h12345; req_asid = 10'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_r_index", tlb_r_index, 0);
    for (int i = 0; i < 4; i++) begin
      check("mid_rst_no_refill", refill_valid, 0);
      check("mid_rst_no_resp", resp_valid, 0);
      @(negedge clk);
    end
    run_vec(vecs[4]);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
